// File: rtl/tile_operand_loader.sv
// Collects one operand frame (config, vector A, vector B) from the network and writes it
// to the register file ports, with ack tracking, timed retries and a sticky error state.
module tile_operand_loader #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rf_busy,
    output logic             wen1,
    output logic [WIDTH-1:0] w_data1 [NUM_INPUTS],
    input  logic             wr_ack1,
    output logic             wen2,
    output logic [WIDTH-1:0] w_data2 [NUM_INPUTS],
    input  logic             wr_ack2,
    output logic             wen3,
    output logic [WIDTH-1:0] w_data3,
    input  logic             wr_ack3,
    output logic             load_done,
    output logic             err,
    output logic [7:0]       frames_loaded
);

    localparam int unsigned FRAME_LEN = 2 * NUM_INPUTS + 1;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned TIMER_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_COLLECT  = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DONE     = 3'd3,
        S_ERROR    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [2:0]           seen_q, seen_d;
    logic                 wen_q, wen_d;
    logic                 load_done_q, load_done_d;
    logic                 err_q, err_d;
    logic [7:0]           frames_q, frames_d;
    logic [WIDTH-1:0]     cfg_q, cfg_d;
    logic [WIDTH-1:0]     a_q [NUM_INPUTS];
    logic [WIDTH-1:0]     a_d [NUM_INPUTS];
    logic [WIDTH-1:0]     b_q [NUM_INPUTS];
    logic [WIDTH-1:0]     b_d [NUM_INPUTS];

    logic                 xfer;
    logic                 last_word;
    logic [2:0]           seen_now;
    logic                 all_acked;
    logic                 timed_out;
    logic                 retries_spent;

    assign in_ready      = (state_q == S_COLLECT) && !reset;
    assign xfer          = in_valid && in_ready;
    assign last_word     = (idx_q == IDX_W'(FRAME_LEN - 1));
    assign seen_now      = seen_q | {wr_ack3, wr_ack2, wr_ack1};
    assign all_acked     = &seen_now;
    assign timed_out     = (timer_q == TIMER_W'(ACK_TIMEOUT - 1));
    assign retries_spent = (retry_q == RETRY_W'(MAX_RETRY));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; all-acks wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_COLLECT:  if (xfer && last_word) state_d = S_ISSUE;
            S_ISSUE:    if (!rf_busy) state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (all_acked) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = retries_spent ? S_ERROR : S_ISSUE;
                end
            end
            S_DONE:     state_d = S_COLLECT;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_COLLECT;
        endcase
    end

    // Datapath / registered-output next values
    always_comb begin
        idx_d       = idx_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        seen_d      = seen_q;
        wen_d       = 1'b0;
        load_done_d = 1'b0;
        err_d       = err_q;
        frames_d    = frames_q;
        cfg_d       = cfg_q;
        a_d         = a_q;
        b_d         = b_q;
        unique case (state_q)
            S_COLLECT: begin
                if (xfer) begin
                    if (idx_q == '0) cfg_d = in_data;
                    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                        if (idx_q == IDX_W'(i + 1)) a_d[i] = in_data;
                        if (idx_q == IDX_W'(i + 1 + NUM_INPUTS)) b_d[i] = in_data;
                    end
                    idx_d = last_word ? '0 : idx_q + IDX_W'(1);
                end
            end
            S_ISSUE: begin
                if (!rf_busy) begin
                    wen_d   = 1'b1;
                    seen_d  = '0;
                    timer_d = '0;
                end
            end
            S_WAIT_ACK: begin
                seen_d = seen_now;
                if (all_acked) begin
                    load_done_d = 1'b1;
                    frames_d    = frames_q + 8'd1;
                end else if (timed_out) begin
                    if (retries_spent) err_d = 1'b1;
                    else retry_d = retry_q + RETRY_W'(1);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_DONE:  retry_d = '0;
            S_ERROR: err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            seen_q      <= '0;
            wen_q       <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
            cfg_q       <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            seen_q      <= seen_d;
            wen_q       <= wen_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
            cfg_q       <= cfg_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign wen1          = wen_q;
    assign wen2          = wen_q;
    assign wen3          = wen_q;
    assign w_data1       = a_q;
    assign w_data2       = b_q;
    assign w_data3       = cfg_q;
    assign load_done     = load_done_q;
    assign err           = err_q;
    assign frames_loaded = frames_q;

endmodule

// File: tb/tb_tile_operand_loader.sv
// Randomized bench for tile_operand_loader: frames, backpressure, ack timing, retry/error, reset, wrap.
module tb_tile_operand_loader;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 4;
    localparam int unsigned T     = 8;
    localparam int unsigned MR    = 3;
    localparam int unsigned FL    = 2 * N + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             rf_busy;
    logic             wen1, wen2, wen3;
    logic [WIDTH-1:0] w_data1 [N];
    logic [WIDTH-1:0] w_data2 [N];
    logic [WIDTH-1:0] w_data3;
    logic             wr_ack1, wr_ack2, wr_ack3;
    logic             load_done;
    logic             err;
    logic [7:0]       frames_loaded;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_frames;
    logic [WIDTH-1:0] fw [FL];

    always #5 clk = ~clk;

    tile_operand_loader #(.WIDTH(WIDTH), .NUM_INPUTS(N), .ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rf_busy(rf_busy),
        .wen1(wen1), .w_data1(w_data1), .wr_ack1(wr_ack1),
        .wen2(wen2), .w_data2(w_data2), .wr_ack2(wr_ack2),
        .wen3(wen3), .w_data3(w_data3), .wr_ack3(wr_ack3),
        .load_done(load_done), .err(err), .frames_loaded(frames_loaded)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; rf_busy = 1'b0;
        wr_ack1 = 1'b0; wr_ack2 = 1'b0; wr_ack3 = 1'b0;
        step(); step();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_wen", {wen1, wen2, wen3}, 0);
        check_eq("rst_load_done", load_done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_frames", frames_loaded, 0);
        check_eq("rst_wdata", {w_data1[0], w_data2[N-1], w_data3}, 0);
        reset = 1'b0;
        step();
        check_eq("post_rst_wen", {wen1, wen2, wen3}, 0);
        check_eq("post_rst_load_done", load_done, 0);
        check_eq("post_rst_in_ready", in_ready, 1);
        exp_frames = 0;
    endtask

    task automatic random_frame();
        for (int i = 0; i < int'(FL); i++) fw[i] = WIDTH'($urandom);
    endtask

    // Send fw with random valid gaps; raise rf_busy with the last word when busy > 0
    task automatic send_frame(input int unsigned busy);
        for (int i = 0; i < int'(FL); i++) begin
            int  guard = 0;
            bit  done  = 1'b0;
            while (!done) begin
                if ($urandom_range(3) == 0) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    in_data  = fw[i];
                end
                if (i == int'(FL) - 1) rf_busy = (busy != 0);
                done = in_valid && in_ready;
                step();
                guard++;
                if (!done && guard > 50) begin
                    check_eq("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    // From the ISSUE cycle: hold busy, expect one write, ack at per-port delays after the write
    task automatic issue_and_ack(input int unsigned busy, input int unsigned d1,
                                 input int unsigned d2, input int unsigned d3);
        int unsigned mx;
        for (int unsigned k = 0; k < busy; k++) begin
            check_eq("wen_while_busy", {wen1, wen2, wen3}, 0);
            check_eq("rdy_while_busy", in_ready, 0);
            step();
        end
        rf_busy = 1'b0;
        check_eq("wen_before_issue", {wen1, wen2, wen3}, 0);
        step();
        check_eq("wen_pulse", {wen1, wen2, wen3}, 3'b111);
        check_eq("w_data3", w_data3, fw[0]);
        for (int i = 0; i < int'(N); i++) begin
            check_eq("w_data1", w_data1[i], fw[1+i]);
            check_eq("w_data2", w_data2[i], fw[1+N+i]);
        end
        mx = d1;
        if (d2 > mx) mx = d2;
        if (d3 > mx) mx = d3;
        for (int unsigned k = 0; k <= mx; k++) begin
            wr_ack1 = (d1 == k);
            wr_ack2 = (d2 == k);
            wr_ack3 = (d3 == k);
            step();
            check_eq("load_done_timing", load_done, (k == mx));
            check_eq("no_rewrite", {wen1, wen2, wen3}, 0);
            check_eq("w_data3_hold", w_data3, fw[0]);
        end
        wr_ack1 = 1'b0; wr_ack2 = 1'b0; wr_ack3 = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
        check_eq("frames_loaded", frames_loaded, exp_frames);
        step();
        check_eq("load_done_one_cycle", load_done, 0);
        check_eq("back_to_collect", in_ready, 1);
    endtask

    initial begin
        in_data = '0;
        exp_frames = 0;
        do_reset();

        // Nominal frame, acks one cycle after the write
        fw[0] = 16'h00C1;
        for (int i = 0; i < int'(N); i++) begin
            fw[1+i]   = WIDTH'(i + 1);
            fw[1+N+i] = WIDTH'(16'h11 + i);
        end
        send_frame(0);
        issue_and_ack(0, 1, 1, 1);

        // Register-file backpressure for 5 cycles
        random_frame();
        send_frame(5);
        issue_and_ack(5, 1, 1, 1);

        // Staggered acks: 3, then 1, then 2
        random_frame();
        send_frame(0);
        issue_and_ack(0, 3, 5, 1);

        // Final ack lands in the timeout cycle
        random_frame();
        send_frame(0);
        issue_and_ack(0, T - 1, 0, 2);

        // Never ack: MR+1 attempts, each T+1 cycles long, then sticky error
        random_frame();
        send_frame(0);
        check_eq("err_wen_pre", {wen1, wen2, wen3}, 0);
        step();
        for (int unsigned c = 0; c < (MR + 1) * (T + 1) + 6; c++) begin
            check_eq("retry_wen", wen1 && wen2 && wen3,
                     ((c % (T + 1)) == 0) && (c / (T + 1) <= MR));
            check_eq("err_flag", err, c >= (MR + 1) * (T + 1) - 1);
            check_eq("err_in_ready", in_ready, 0);
            step();
        end
        check_eq("err_sticky_frames", frames_loaded, exp_frames);

        // Reset clears error; then reset in the middle of a frame
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = WIDTH'(16'hBEE0 + i);
            check_eq("mid_frame_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        do_reset();
        random_frame();
        send_frame(0);
        issue_and_ack(0, 0, 1, 0);
        check_eq("frames_after_reset", frames_loaded, 1);

        // Random frames until the counter wraps past 255
        while (exp_frames != 0) begin
            random_frame();
            begin
                int unsigned b = $urandom_range(0, 3);
                send_frame(b);
                issue_and_ack(b, $urandom_range(0, T - 1), $urandom_range(0, T - 1),
                              $urandom_range(0, T - 1));
            end
        end
        check_eq("frames_wrap", frames_loaded, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_operand_loader.md
TILE_OPERAND_LOADER -- requirements
Module: tile_operand_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, elements per operand vector.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8, cycles allowed in WAIT_ACK before a retry.
REQ-004 SHALL have parameter MAX_RETRY, default 3, retries allowed before error.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  network word valid.
- in_ready  out  1  loader accepts word.
- in_data  in  WIDTH  network word.
- rf_busy  in  1  register file is being read; writes are not issued while high.
- wen1  out  1  vector A write strobe.
- w_data1  out  NUM_INPUTS x WIDTH (unpacked)  vector A.
- wr_ack1  in  1  vector A write acknowledge.
- wen2  out  1  vector B write strobe.
- w_data2  out  NUM_INPUTS x WIDTH (unpacked)  vector B.
- wr_ack2  in  1  vector B write acknowledge.
- wen3  out  1  config write strobe.
- w_data3  out  WIDTH  config word.
- wr_ack3  in  1  config write acknowledge.
- load_done  out  1  one-cycle pulse on frame commit.
- err  out  1  sticky retry-exhausted flag.
- frames_loaded  out  8  committed frame count, wraps 255->0.

Function
REQ-006 SHALL implement states COLLECT, ISSUE, WAIT_ACK, DONE, ERROR.
REQ-007 SHALL define a frame as 2*NUM_INPUTS+1 words in this order: word 0 = config, words 1..NUM_INPUTS = vector A elements 0..N-1, following NUM_INPUTS words = vector B elements 0..N-1.
REQ-008 SHALL drive in_ready=1 only in COLLECT with reset low; a word transfers on in_valid & in_ready.
REQ-009 SHALL, in COLLECT, store each transferred word into its frame slot per a word index that increments per transfer.
REQ-010 SHALL, on transfer of the last frame word, reset the word index to 0 and enter ISSUE next cycle.
REQ-011 SHALL, in ISSUE with rf_busy=0, assert wen1, wen2 and wen3 together for exactly one cycle, clear the ack-seen flags and the timer, and enter WAIT_ACK.
REQ-012 SHALL, in ISSUE with rf_busy=1, hold all wen low and remain in ISSUE.
REQ-013 SHALL hold w_data1, w_data2 and w_data3 stable from ISSUE entry until the state leaves WAIT_ACK.
REQ-014 SHALL, in WAIT_ACK, set a sticky seen flag per wr_ackN; acks arriving in the same cycle count together.
REQ-015 SHALL enter DONE when all three seen flags, including acks arriving that cycle, are set.
REQ-016 SHALL ignore wr_ackN pulses in any state other than WAIT_ACK.
REQ-017 SHALL increment the timer each WAIT_ACK cycle; when the timer reaches ACK_TIMEOUT-1 without all acks, increment the retry count and return to ISSUE, which reissues all three ports.
REQ-018 SHALL, when a timeout occurs with retry count already equal to MAX_RETRY, enter ERROR instead of ISSUE.
REQ-019 SHALL give all-acks precedence over timeout in the same cycle.
REQ-020 SHALL, in DONE, pulse load_done for one cycle, increment frames_loaded, clear the retry count, and return to COLLECT.
REQ-021 SHALL, in ERROR, set err=1, drive in_ready=0 and all wen=0, and remain in ERROR until reset.

Reset
REQ-022 SHALL, while reset is high, set state=COLLECT, word index=0, timer=0, retry=0, seen flags=0, wen1..3=0, load_done=0, err=0, frames_loaded=0, w_data1/2/3=0, and drive in_ready=0.
REQ-023 SHALL, on reset mid-frame or mid-WAIT_ACK, discard the partial frame, with no wen or load_done asserted in the cycle after reset deasserts.

Verification
REQ-024 Nominal: send 9 words 0x00C1, 0x0001..0x0004, 0x0011..0x0014, with rf_busy=0 and all acks one cycle after wen -> one wen pulse, w_data1={1,2,3,4}, w_data2={0x11..0x14}, w_data3=0x00C1, load_done pulse, frames_loaded=1.
REQ-025 Backpressure: hold rf_busy=1 for 5 cycles after the last word -> wen stays low for those 5 cycles, then pulses once, and in_ready=0 throughout.
REQ-026 Staggered acks: wr_ack3, then wr_ack1 two cycles later, then wr_ack2 two cycles after that -> load_done pulses in the cycle after wr_ack2, with no retry.
REQ-027 Retry then error: never ack -> wen pulses 4 times, spaced ACK_TIMEOUT+1 cycles apart, then err=1 and in_ready=0, held until reset.
REQ-028 Reset mid-frame after 5 words, then send a full new frame -> the new frame's words land in slots 0..8 and frames_loaded=1.
REQ-029 Wrap: commit 256 frames -> frames_loaded returns to 0.
